decode_dispatch_queue: RTL and testbench
========================================

Name: decode_dispatch_queue

Overview:
Consumer end of the decode-mux output stream. Captures each enabled decoded instruction into an in-order circular queue. Presents the head entry to the functional unit selected by its funcUnitType, using a per-unit valid/ready handshake. The mux has no backpressure, so the queue raises an early stall_o toward fetch/decode and flags overflow.

Parameters:
addressWidth, 64, instruction address width
instructionCounterWidth, 64, major ID width
instMinIdWidth, 7, minor ID width
opcodeSize, 12, opcode width
PidSize, 20, process ID width
TidSize, 16, thread ID width
regAccessPatternSize, 2, per-operand rw flag width
funcUnitCodeSize, 3, unit code width; 2**funcUnitCodeSize dispatch lanes
queueDepth, 8, entries; power of two
queueIdxBits, 3, log2(queueDepth)
stallThreshold, 2, free-entry count at or below which stall_o asserts

Ports:
clock_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  discard all queued entries (mispredict/exception)
enable_i  in  1  decoded instruction valid this cycle
instFormat_i  in  25  one-hot format code
opcode_i  in  opcodeSize  internal opcode
address_i  in  addressWidth  instruction address
funcUnitType_i  in  funcUnitCodeSize  target unit code
majID_i  in  instructionCounterWidth  major ID
minID_i  in  instMinIdWidth  minor ID
is64Bit_i  in  1  64-bit mode
pid_i / tid_i  in  PidSize / TidSize  process / thread ID
op1rw_i..op4rw_i  in  regAccessPatternSize each  operand rw flags
op1IsReg_i..op4IsReg_i  in  1 each  operand-is-register flags
body_i  in  84  operand body (regs + 64b imm)
unitReady_i  in  2**funcUnitCodeSize  per-unit ready, indexed by unit code
unitValid_o  out  2**funcUnitCodeSize  one-hot valid for head entry's unit
inst*_o  out  same widths as inputs  head entry fields (format, opcode, address, unit, IDs, mode, pid/tid, rw, isReg, body)
count_o  out  queueIdxBits+1  occupancy
stall_o  out  1  upstream must stop issuing
overflow_o  out  1  sticky; an enable was dropped

Behaviour:
- Storage: queueDepth-entry array, head/tail pointers of queueIdxBits bits, wrapping naturally. count is a separate register of queueIdxBits+1 bits.
- Push: on posedge with enable_i && !flush_i, write all input fields at tail, tail+1. Accepted if count<queueDepth, or if a pop occurs the same cycle.
- Dropped push: when full and no pop, the push is dropped, overflow_o set (sticky until reset), and state is unchanged.
- Head outputs: inst*_o reflect array[head] combinationally from registers, so an entry pushed at edge N is visible after edge N (1-cycle latency).
- unitValid_o: bit funcUnitType of head is 1 iff count>0 && !flush_i. All other bits are 0.
- Pop: on posedge, when unitValid_o[u] && unitReady_i[u]. head+1. Strictly in order: a non-ready head blocks all younger entries, even when their units are ready.
- Occupancy: push+pop in the same cycle leaves count unchanged (also when full or when count=1).
- stall_o: registered, = (queueDepth - next_count) <= stallThreshold. It covers the 2-cycle decode pipeline delay.
- Flush: head=tail=0, count=0, stall_o=0 next cycle. Any same-cycle push and pop are ignored. overflow_o is kept.
- Reset (takes priority over everything, including mid-stream): head=tail=count=0, stall_o=0, overflow_o=0, unitValid_o=0. Array contents are don't-care, but inst*_o are zero-driven while count=0.

Optional Feature:
DISPATCH_QUEUE_STATS_EN: adds outputs enqCount_o, deqCount_o, dropCount_o, each 32 bits, and stallCycles_o (32 bits).
- Counters are cleared on reset, not on flush, and saturate at all-ones.
- enqCount_o: accepted pushes. deqCount_o: pops. dropCount_o: dropped pushes. stallCycles_o: cycles with stall_o=1.
- Without the macro, these ports and the counters do not exist.

Test Plan:
- Reset, then push 3 entries (majID 1,2,3, unit 0) with unitReady_i=0 -> count_o=3, unitValid_o=8'b0000_0001, majID_o=1, stall_o=0.
- Set unitReady_i[0]=1 with one push per cycle -> count_o stays constant, majIDs appear in order 1,2,3,... one per cycle.
- Head unit 4 (LS) not ready, next entry unit 0 ready -> no pop, unitValid_o=8'b0001_0000, count_o unchanged.
- 8 pushes, no pops -> stall_o=1 after the 6th push. The 9th push is dropped: overflow_o=1, count_o=8, head majID unchanged. With the stats macro, dropCount_o=1.
- Full queue, push and pop in the same cycle -> push accepted, count_o=8, overflow_o=0.
- 5 entries queued, then flush_i with a simultaneous enable_i -> next cycle count_o=0, unitValid_o=0, incoming entry not stored. A following push has majID_o equal to the new entry.

Source files
------------

// File: rtl/decode_dispatch_queue.sv
// decode_dispatch_queue
// In-order circular queue at the consumer end of the decode-mux stream.
// Each enabled decoded instruction is captured at the tail. The head entry is
// offered to the functional unit named by its funcUnitType through a per-unit
// valid/ready handshake. The mux cannot be back-pressured, so an early,
// registered stall_o goes to fetch/decode and a sticky overflow_o flags any
// dropped instruction.
// Optional build macro: DISPATCH_QUEUE_STATS_EN adds saturating 32-bit
// enqueue/dequeue/drop/stall-cycle counters.
module decode_dispatch_queue #(
   parameter int addressWidth            = 64,
   parameter int instructionCounterWidth = 64,
   parameter int instMinIdWidth          = 7,
   parameter int opcodeSize              = 12,
   parameter int PidSize                 = 20,
   parameter int TidSize                 = 16,
   parameter int regAccessPatternSize    = 2,
   parameter int funcUnitCodeSize        = 3,
   parameter int queueDepth              = 8,
   parameter int queueIdxBits            = 3,
   parameter int stallThreshold          = 2
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               flush_i,
   input  logic                               enable_i,
   input  logic [24:0]                        instFormat_i,
   input  logic [opcodeSize-1:0]              opcode_i,
   input  logic [addressWidth-1:0]            address_i,
   input  logic [funcUnitCodeSize-1:0]        funcUnitType_i,
   input  logic [instructionCounterWidth-1:0] majID_i,
   input  logic [instMinIdWidth-1:0]          minID_i,
   input  logic                               is64Bit_i,
   input  logic [PidSize-1:0]                 pid_i,
   input  logic [TidSize-1:0]                 tid_i,
   input  logic [regAccessPatternSize-1:0]    op1rw_i,
   input  logic [regAccessPatternSize-1:0]    op2rw_i,
   input  logic [regAccessPatternSize-1:0]    op3rw_i,
   input  logic [regAccessPatternSize-1:0]    op4rw_i,
   input  logic                               op1IsReg_i,
   input  logic                               op2IsReg_i,
   input  logic                               op3IsReg_i,
   input  logic                               op4IsReg_i,
   input  logic [83:0]                        body_i,
   input  logic [2**funcUnitCodeSize-1:0]     unitReady_i,
   output logic [2**funcUnitCodeSize-1:0]     unitValid_o,
   output logic [24:0]                        instFormat_o,
   output logic [opcodeSize-1:0]              opcode_o,
   output logic [addressWidth-1:0]            address_o,
   output logic [funcUnitCodeSize-1:0]        funcUnitType_o,
   output logic [instructionCounterWidth-1:0] majID_o,
   output logic [instMinIdWidth-1:0]          minID_o,
   output logic                               is64Bit_o,
   output logic [PidSize-1:0]                 pid_o,
   output logic [TidSize-1:0]                 tid_o,
   output logic [regAccessPatternSize-1:0]    op1rw_o,
   output logic [regAccessPatternSize-1:0]    op2rw_o,
   output logic [regAccessPatternSize-1:0]    op3rw_o,
   output logic [regAccessPatternSize-1:0]    op4rw_o,
   output logic                               op1IsReg_o,
   output logic                               op2IsReg_o,
   output logic                               op3IsReg_o,
   output logic                               op4IsReg_o,
   output logic [83:0]                        body_o,
   output logic [queueIdxBits:0]              count_o,
   output logic                               stall_o,
`ifdef DISPATCH_QUEUE_STATS_EN
   output logic [31:0]                        enqCount_o,
   output logic [31:0]                        deqCount_o,
   output logic [31:0]                        dropCount_o,
   output logic [31:0]                        stallCycles_o,
`endif
   output logic                               overflow_o
);

   localparam int ENTRY_W = 25 + opcodeSize + addressWidth + funcUnitCodeSize
                          + instructionCounterWidth + instMinIdWidth + 1
                          + PidSize + TidSize + 4 * regAccessPatternSize + 4 + 84;
   localparam logic [queueIdxBits:0] DEPTH_C = (queueIdxBits + 1)'(queueDepth);
   localparam logic [queueIdxBits:0] THR_C   = (queueIdxBits + 1)'(stallThreshold);

   logic [ENTRY_W-1:0]      mem [queueDepth];
   logic [ENTRY_W-1:0]      wr_entry;
   logic [ENTRY_W-1:0]      head_entry;
   logic [queueIdxBits-1:0] head;
   logic [queueIdxBits-1:0] tail;
   logic [queueIdxBits:0]   count;
   logic [queueIdxBits:0]   next_count;
   logic [queueIdxBits:0]   free_next;
   logic                    not_empty;
   logic                    full;
   logic                    push_req;
   logic                    push_ok;
   logic                    drop;
   logic                    pop;
   logic                    stall_next;

   // All fields travel together as one packed entry; unpack order mirrors pack order.
   assign wr_entry = {instFormat_i, opcode_i, address_i, funcUnitType_i, majID_i,
                      minID_i, is64Bit_i, pid_i, tid_i, op1rw_i, op2rw_i, op3rw_i,
                      op4rw_i, op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i, body_i};

   assign {instFormat_o, opcode_o, address_o, funcUnitType_o, majID_o,
           minID_o, is64Bit_o, pid_o, tid_o, op1rw_o, op2rw_o, op3rw_o,
           op4rw_o, op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o, body_o} = head_entry;

   assign not_empty = (count != {(queueIdxBits + 1){1'b0}});
   assign full      = (count == DEPTH_C);
   assign count_o   = count;

   // Head fields come straight from storage, forced to zero while the queue is empty.
   always_comb begin
      head_entry = {ENTRY_W{1'b0}};
      if (not_empty) begin
         head_entry = mem[head];
      end else begin
         head_entry = {ENTRY_W{1'b0}};
      end
   end

   // One-hot valid toward the head entry's unit; a flush suppresses it immediately.
   always_comb begin
      unitValid_o = {(2**funcUnitCodeSize){1'b0}};
      if (not_empty && !flush_i) begin
         unitValid_o[funcUnitType_o] = 1'b1;
      end else begin
         unitValid_o = {(2**funcUnitCodeSize){1'b0}};
      end
   end

   // Pop only the head; a stalled head blocks younger entries. Push may reuse a slot freed by a same-cycle pop.
   always_comb begin
      pop      = |(unitValid_o & unitReady_i);
      push_req = enable_i && !flush_i;
      push_ok  = push_req && (!full || pop);
      drop     = push_req && full && !pop;
   end

   // Next occupancy and the early stall it implies for the decode pipeline.
   always_comb begin
      next_count = count;
      if (flush_i) begin
         next_count = {(queueIdxBits + 1){1'b0}};
      end else if (push_ok && !pop) begin
         next_count = count + {{queueIdxBits{1'b0}}, 1'b1};
      end else if (pop && !push_ok) begin
         next_count = count - {{queueIdxBits{1'b0}}, 1'b1};
      end else begin
         next_count = count;
      end
      free_next  = DEPTH_C - next_count;
      stall_next = (free_next <= THR_C);
   end

   // Pointer, occupancy, stall and sticky overflow state.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         head       <= {queueIdxBits{1'b0}};
         tail       <= {queueIdxBits{1'b0}};
         count      <= {(queueIdxBits + 1){1'b0}};
         stall_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else if (flush_i) begin
         head       <= {queueIdxBits{1'b0}};
         tail       <= {queueIdxBits{1'b0}};
         count      <= {(queueIdxBits + 1){1'b0}};
         stall_o    <= 1'b0;
         overflow_o <= overflow_o;
      end else begin
         if (pop) begin
            head <= head + {{(queueIdxBits - 1){1'b0}}, 1'b1};
         end
         if (push_ok) begin
            tail <= tail + {{(queueIdxBits - 1){1'b0}}, 1'b1};
         end
         count      <= next_count;
         stall_o    <= stall_next;
         overflow_o <= overflow_o | drop;
      end
   end

   // Entry storage; contents need no reset because empty slots are never presented.
   always_ff @(posedge clock_i) begin
      if (!reset_i && push_ok) begin
         mem[tail] <= wr_entry;
      end
   end

`ifdef DISPATCH_QUEUE_STATS_EN
   // Increment by one, holding at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
      if (inc && (value != 32'hFFFF_FFFF)) begin
         sat_inc = value + 32'd1;
      end else begin
         sat_inc = value;
      end
   endfunction

   // Saturating event counters; a flush leaves them intact.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         enqCount_o    <= 32'd0;
         deqCount_o    <= 32'd0;
         dropCount_o   <= 32'd0;
         stallCycles_o <= 32'd0;
      end else begin
         enqCount_o    <= sat_inc(enqCount_o, push_ok);
         deqCount_o    <= sat_inc(deqCount_o, pop);
         dropCount_o   <= sat_inc(dropCount_o, drop);
         stallCycles_o <= sat_inc(stallCycles_o, stall_o);
      end
   end
`endif

endmodule

// File: tb/tb_decode_dispatch_queue.sv
// Self-checking bench for decode_dispatch_queue: a scoreboard queue of expected
// entries is pushed when stimulus is accepted and popped when the head dispatches.
module tb_decode_dispatch_queue;

   typedef struct {
      logic [63:0] maj;
      logic [2:0]  unit;
   } ent_t;

   logic         clock_i = 1'b0;
   logic         reset_i, flush_i, enable_i;
   logic [24:0]  instFormat_i;
   logic [11:0]  opcode_i;
   logic [63:0]  address_i;
   logic [2:0]   funcUnitType_i;
   logic [63:0]  majID_i;
   logic [6:0]   minID_i;
   logic         is64Bit_i;
   logic [19:0]  pid_i;
   logic [15:0]  tid_i;
   logic [1:0]   op1rw_i, op2rw_i, op3rw_i, op4rw_i;
   logic         op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
   logic [83:0]  body_i;
   logic [7:0]   unitReady_i;
   logic [7:0]   unitValid_o;
   logic [24:0]  instFormat_o;
   logic [11:0]  opcode_o;
   logic [63:0]  address_o;
   logic [2:0]   funcUnitType_o;
   logic [63:0]  majID_o;
   logic [6:0]   minID_o;
   logic         is64Bit_o;
   logic [19:0]  pid_o;
   logic [15:0]  tid_o;
   logic [1:0]   op1rw_o, op2rw_o, op3rw_o, op4rw_o;
   logic         op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
   logic [83:0]  body_o;
   logic [3:0]   count_o;
   logic         stall_o, overflow_o;
`ifdef DISPATCH_QUEUE_STATS_EN
   logic [31:0]  enqCount_o, deqCount_o, dropCount_o, stallCycles_o;
`endif

   ent_t sb[$];
   logic overflow_m;
   logic stall_m;
   int   n_cmp = 0;
   int   n_err = 0;

   decode_dispatch_queue dut (
      .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .enable_i(enable_i),
      .instFormat_i(instFormat_i), .opcode_i(opcode_i), .address_i(address_i),
      .funcUnitType_i(funcUnitType_i), .majID_i(majID_i), .minID_i(minID_i),
      .is64Bit_i(is64Bit_i), .pid_i(pid_i), .tid_i(tid_i),
      .op1rw_i(op1rw_i), .op2rw_i(op2rw_i), .op3rw_i(op3rw_i), .op4rw_i(op4rw_i),
      .op1IsReg_i(op1IsReg_i), .op2IsReg_i(op2IsReg_i), .op3IsReg_i(op3IsReg_i),
      .op4IsReg_i(op4IsReg_i), .body_i(body_i), .unitReady_i(unitReady_i),
      .unitValid_o(unitValid_o), .instFormat_o(instFormat_o), .opcode_o(opcode_o),
      .address_o(address_o), .funcUnitType_o(funcUnitType_o), .majID_o(majID_o),
      .minID_o(minID_o), .is64Bit_o(is64Bit_o), .pid_o(pid_o), .tid_o(tid_o),
      .op1rw_o(op1rw_o), .op2rw_o(op2rw_o), .op3rw_o(op3rw_o), .op4rw_o(op4rw_o),
      .op1IsReg_o(op1IsReg_o), .op2IsReg_o(op2IsReg_o), .op3IsReg_o(op3IsReg_o),
      .op4IsReg_o(op4IsReg_o), .body_o(body_o), .count_o(count_o), .stall_o(stall_o),
`ifdef DISPATCH_QUEUE_STATS_EN
      .enqCount_o(enqCount_o), .deqCount_o(deqCount_o), .dropCount_o(dropCount_o),
      .stallCycles_o(stallCycles_o),
`endif
      .overflow_o(overflow_o)
   );

   always #5 clock_i = ~clock_i;

   // Drive one cycle of stimulus, advance the scoreboard model, then idle the strobes.
   task automatic step(input logic en, input logic [63:0] maj, input logic [2:0] unit, input logic fl);
      logic pop_m, acc_m, drop_m;
      ent_t e;
      enable_i       = en;
      flush_i        = fl;
      majID_i        = maj;
      funcUnitType_i = unit;
      minID_i        = maj[6:0] ^ 7'h2A;
      opcode_i       = maj[11:0] + 12'h100;
      address_i      = {maj[31:0], ~maj[31:0]};
      body_i         = {20'h5A5A5, maj};
      pop_m  = (sb.size() > 0) && !fl && unitReady_i[sb[0].unit];
      acc_m  = en && !fl && ((sb.size() < 8) || pop_m);
      drop_m = en && !fl && (sb.size() == 8) && !pop_m;
      @(posedge clock_i);
      #1;
      enable_i = 1'b0;
      flush_i  = 1'b0;
      if (fl) begin
         sb.delete();
      end else begin
         if (pop_m) void'(sb.pop_front());
         if (acc_m) begin
            e.maj  = maj;
            e.unit = unit;
            sb.push_back(e);
         end
      end
      overflow_m = overflow_m | drop_m;
      stall_m    = (8 - sb.size()) <= 2;
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      enable_i    = 1'b0;
      flush_i     = 1'b0;
      unitReady_i = 8'h00;
      repeat (2) @(posedge clock_i);
      #1;
      reset_i    = 1'b0;
      sb.delete();
      overflow_m = 1'b0;
      stall_m    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count_o); end
      n_cmp++; if (unitValid_o !== 8'h00) begin n_err++; $display("FAIL reset_valid got %h want 00", unitValid_o); end
      n_cmp++; if (stall_o !== 1'b0 || overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_flags got stall=%b ovf=%b want 0 0", stall_o, overflow_o); end
      n_cmp++; if (majID_o !== 64'd0) begin n_err++; $display("FAIL reset_head got %0d want 0", majID_o); end
   endtask

   task automatic test_fill_hold();
      for (int i = 1; i <= 3; i++) step(1'b1, 64'(i), 3'd0, 1'b0);
      n_cmp++; if (int'(count_o) !== sb.size()) begin n_err++; $display("FAIL hold_count got %0d want %0d", count_o, sb.size()); end
      n_cmp++; if (unitValid_o !== 8'b0000_0001) begin n_err++; $display("FAIL hold_valid got %b want 00000001", unitValid_o); end
      n_cmp++; if (majID_o !== 64'd1) begin n_err++; $display("FAIL hold_head got %0d want 1", majID_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL hold_stall got %b want 0", stall_o); end
   endtask

   task automatic test_stream();
      int guard;
      unitReady_i = 8'h01;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 64'(4 + i), 3'd0, 1'b0);
         n_cmp++; if (count_o !== 4'd3) begin n_err++; $display("FAIL stream_count got %0d want 3", count_o); end
         n_cmp++; if (majID_o !== sb[0].maj) begin n_err++; $display("FAIL stream_head got %0d want %0d", majID_o, sb[0].maj); end
         n_cmp++; if (minID_o !== (sb[0].maj[6:0] ^ 7'h2A)) begin n_err++; $display("FAIL stream_minid got %h want %h", minID_o, sb[0].maj[6:0] ^ 7'h2A); end
      end
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         n_cmp++; if (majID_o !== sb[0].maj) begin n_err++; $display("FAIL drain_head got %0d want %0d", majID_o, sb[0].maj); end
         step(1'b0, 64'd0, 3'd0, 1'b0);
         guard++;
      end
      n_cmp++; if (count_o !== 4'd0 || unitValid_o !== 8'h00) begin n_err++; $display("FAIL drain_empty got count=%0d valid=%h want 0 00", count_o, unitValid_o); end
   endtask

   task automatic test_in_order_block();
      do_reset();
      step(1'b1, 64'd20, 3'd4, 1'b0);
      step(1'b1, 64'd21, 3'd0, 1'b0);
      unitReady_i = 8'h01;
      step(1'b0, 64'd0, 3'd0, 1'b0);
      n_cmp++; if (count_o !== 4'd2) begin n_err++; $display("FAIL block_count got %0d want 2", count_o); end
      n_cmp++; if (unitValid_o !== 8'b0001_0000) begin n_err++; $display("FAIL block_valid got %b want 00010000", unitValid_o); end
      n_cmp++; if (majID_o !== 64'd20 || funcUnitType_o !== 3'd4) begin n_err++; $display("FAIL block_head got %0d/%0d want 20/4", majID_o, funcUnitType_o); end
      unitReady_i = 8'h11;
      step(1'b0, 64'd0, 3'd0, 1'b0);
      n_cmp++; if (majID_o !== sb[0].maj || unitValid_o !== 8'h01) begin n_err++; $display("FAIL unblock_head got %0d/%h want %0d/01", majID_o, unitValid_o, sb[0].maj); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 64'(30 + i), 3'd1, 1'b0);
         n_cmp++; if (stall_o !== stall_m) begin n_err++; $display("FAIL fill_stall push %0d got %b want %b", i + 1, stall_o, stall_m); end
      end
      step(1'b1, 64'd38, 3'd1, 1'b0);
      n_cmp++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow_o); end
      n_cmp++; if (count_o !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d want 8", count_o); end
      n_cmp++; if (majID_o !== 64'd30) begin n_err++; $display("FAIL ovf_head got %0d want 30", majID_o); end
`ifdef DISPATCH_QUEUE_STATS_EN
      n_cmp++; if (dropCount_o !== 32'd1 || enqCount_o !== 32'd8) begin n_err++; $display("FAIL ovf_stats got drop=%0d enq=%0d want 1 8", dropCount_o, enqCount_o); end
`endif
      step(1'b0, 64'd0, 3'd0, 1'b1);
      n_cmp++; if (overflow_o !== overflow_m || count_o !== 4'd0) begin n_err++; $display("FAIL ovf_after_flush got ovf=%b count=%0d want %b 0", overflow_o, count_o, overflow_m); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 64'(40 + i), 3'd0, 1'b0);
      unitReady_i = 8'h01;
      step(1'b1, 64'd50, 3'd0, 1'b0);
      unitReady_i = 8'h00;
      n_cmp++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fullpp_count got %0d want 8", count_o); end
      n_cmp++; if (overflow_o !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf got %b want 0", overflow_o); end
      n_cmp++; if (majID_o !== 64'd41 || stall_o !== 1'b1) begin n_err++; $display("FAIL fullpp_head got %0d stall=%b want 41 1", majID_o, stall_o); end
      n_cmp++; if (sb[7].maj !== 64'd50) begin n_err++; $display("FAIL fullpp_tail got %0d want 50", sb[7].maj); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 64'(60 + i), 3'd2, 1'b0);
      step(1'b1, 64'd70, 3'd2, 1'b1);
      n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", count_o); end
      n_cmp++; if (unitValid_o !== 8'h00 || stall_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got %h stall=%b want 00 0", unitValid_o, stall_o); end
      n_cmp++; if (majID_o !== 64'd0) begin n_err++; $display("FAIL flush_head got %0d want 0", majID_o); end
      step(1'b1, 64'd71, 3'd2, 1'b0);
      n_cmp++; if (majID_o !== sb[0].maj || count_o !== 4'd1) begin n_err++; $display("FAIL flush_repush got %0d count=%0d want %0d 1", majID_o, count_o, sb[0].maj); end
      n_cmp++; if (unitValid_o !== 8'b0000_0100 || address_o !== {32'd71, ~32'd71}) begin n_err++; $display("FAIL flush_repush_fields got valid=%b addr=%h", unitValid_o, address_o); end
   endtask

   initial begin
      instFormat_i = 25'h0000010; is64Bit_i = 1'b1; pid_i = 20'hABCDE; tid_i = 16'h1234;
      op1rw_i = 2'd1; op2rw_i = 2'd2; op3rw_i = 2'd3; op4rw_i = 2'd0;
      op1IsReg_i = 1'b1; op2IsReg_i = 1'b0; op3IsReg_i = 1'b1; op4IsReg_i = 1'b0;
      enable_i = 1'b0; flush_i = 1'b0; reset_i = 1'b1; unitReady_i = 8'h00;
      majID_i = 64'd0; minID_i = 7'd0; opcode_i = 12'd0; address_i = 64'd0;
      funcUnitType_i = 3'd0; body_i = 84'd0; overflow_m = 1'b0; stall_m = 1'b0;
      test_reset();
      test_fill_hold();
      test_stream();
      test_in_order_block();
      test_overflow();
      test_full_push_pop();
      test_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
